otp_auth_ctrl: RTL and testbench
================================

OTP_AUTH_CTRL -- requirements
Module: otp_auth_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of OTP digits (>=1).
REQ-002 The block SHALL have parameter DIGIT_W, default 4, bits per digit.
REQ-003 The block SHALL have parameter EXPIRE_CYCLES, default 2_500_000_000, entry window length in cycles.
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 250_000_000, duration of the unlock, lockout and expired indications in cycles.
REQ-005 The block SHALL have parameter MAX_ATTEMPTS, default 3, wrong entries allowed before lockout (>=1).
REQ-006 The block SHALL have ports: clk input 1 clock; reset input 1, asynchronous, active-low.
REQ-007 The block SHALL have ports: lfsr_code input NUM_DIGITS*DIGIT_W generated code; lfsr_latch input 1 code valid; user_digit input DIGIT_W; user_latch input 1 digit strobe; user_bksp input 1 backspace strobe.
REQ-008 The block SHALL have ports: unlock, reset_sys, expired output 1 each; wrng_atmpt output clog2(MAX_ATTEMPTS+1); otp and user_otp_out output NUM_DIGITS*DIGIT_W, with digit 0 in the MSBs.

Function
REQ-009 The block SHALL implement states IDLE, GEN, ENTER, CHECK, GRANT, LOCKOUT and EXPIRED, with all outputs registered.
REQ-010 IDLE SHALL last one cycle, clear otp, the digit buffer, index, timer and wrng_atmpt, and then move to GEN.
REQ-011 GEN SHALL wait for lfsr_latch, capture lfsr_code into otp on that edge, clear the timer and move to ENTER.
REQ-012 lfsr_latch SHALL be ignored outside GEN, and user_latch and user_bksp SHALL be ignored outside ENTER.
REQ-013 In ENTER, the timer SHALL increment every cycle and SHALL NOT be cleared by a wrong attempt; it is a session timer.
REQ-014 In ENTER with user_latch, the block SHALL store user_digit at the index and increment the index; on the latch of digit NUM_DIGITS-1 it SHALL move to CHECK.
REQ-015 In the ENTER cycle where the timer equals EXPIRE_CYCLES-1, the block SHALL move to EXPIRED, and a simultaneous user_latch SHALL be dropped.
REQ-016 CHECK SHALL last one cycle and compare otp with the buffer.
REQ-017 On a match, CHECK SHALL move to GRANT.
REQ-018 On a mismatch with wrng_atmpt < MAX_ATTEMPTS-1, CHECK SHALL increment wrng_atmpt, clear the buffer and index, and return to ENTER.
REQ-019 On a mismatch with wrng_atmpt == MAX_ATTEMPTS-1, CHECK SHALL set wrng_atmpt to MAX_ATTEMPTS and move to LOCKOUT.
REQ-020 unlock, reset_sys and expired SHALL be high exactly while in GRANT, LOCKOUT and EXPIRED respectively, for exactly HOLD_CYCLES cycles each, followed by IDLE.
REQ-021 The timer SHALL be cleared on entry to GRANT, LOCKOUT and EXPIRED and reused as the hold counter.
REQ-022 user_otp_out SHALL reflect the buffer continuously, with unentered digits reading 0.
REQ-023 The timer width SHALL be clog2(max(EXPIRE_CYCLES, HOLD_CYCLES)), with no wrap-around reachable.

Reset
REQ-024 Asserting reset SHALL, at any time including mid-entry or mid-hold, force IDLE and drive unlock, reset_sys, expired, wrng_atmpt, otp, user_otp_out, the index and the timer to 0.
REQ-025 The first post-reset state SHALL be IDLE.

Configuration
REQ-026 With OTP_BACKSPACE_EN defined, user_bksp in ENTER with index > 0 SHALL decrement the index and zero that digit.
REQ-027 With OTP_BACKSPACE_EN defined, user_bksp at index 0 SHALL have no effect.
REQ-028 With OTP_BACKSPACE_EN defined, simultaneous user_bksp and user_latch SHALL give backspace priority and drop the digit.
REQ-029 Without OTP_BACKSPACE_EN, the user_bksp port SHALL exist and be ignored.

Structure
REQ-030 Package otp_auth_pkg SHALL hold the state typedef/encoding and the default parameter constants.
REQ-031 Sub-module otp_digit_buffer (NUM_DIGITS x DIGIT_W storage, index, write/backspace/clear, flattened output) SHALL be instantiated once.
REQ-032 The FSM, timer and comparator SHALL reside in otp_auth_ctrl.

Verification (NUM_DIGITS=4, DIGIT_W=4, EXPIRE_CYCLES=100, HOLD_CYCLES=10, MAX_ATTEMPTS=3)
REQ-033 Correct entry: lfsr_code=0x1234 latched, digits 1,2,3,4 -> unlock high exactly 10 cycles starting 2 cycles after the 4th latch, then IDLE with otp=0.
REQ-034 Lockout: three wrong entries 0x0000 -> wrng_atmpt steps 1,2,3 -> reset_sys high 10 cycles -> IDLE with wrng_atmpt=0.
REQ-035 Expiry: code latched, 2 digits entered, idle until cycle 100 -> expired high 10 cycles; a user_latch on the expiry cycle leaves user_otp_out unchanged.
REQ-036 Backspace (macro on): digits 1,9,bksp,2,3,4 against 0x1234 -> unlock; bksp at index 0 -> no change; with the macro off, the same sequence -> mismatch, wrng_atmpt=1.
REQ-037 Reset mid-GRANT at hold cycle 5 -> unlock=0 immediately, state IDLE; lfsr_latch pulsed during ENTER -> otp unchanged.

Source files
------------

// File: rtl/otp_auth_pkg.sv
// Shared types and default constants for the OTP authentication controller.
// State encoding, default parameter values and the timer-width helper live here.
package otp_auth_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GEN,
      ENTER,
      CHECK,
      GRANT,
      LOCKOUT,
      EXPIRED
   } state_t;

   localparam int unsigned     DEF_NUM_DIGITS    = 4;
   localparam int unsigned     DEF_DIGIT_W       = 4;
   localparam longint unsigned DEF_EXPIRE_CYCLES = 64'd2_500_000_000;
   localparam longint unsigned DEF_HOLD_CYCLES   = 64'd250_000_000;
   localparam int unsigned     DEF_MAX_ATTEMPTS  = 3;

   // One timer serves both the entry window and the hold periods.
   function automatic int unsigned tmr_width(longint unsigned a, longint unsigned b);
      longint unsigned m;
      m = (a > b) ? a : b;
      return (m < 64'd2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/otp_auth_ctrl_if.sv
// Signal bundle between the OTP controller (slave) and its code source / keypad
// side (master). Widths must match the parameters of the attached otp_auth_ctrl.
interface otp_auth_ctrl_if
   import otp_auth_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
   parameter int unsigned DIGIT_W      = DEF_DIGIT_W,
   parameter int unsigned MAX_ATTEMPTS = DEF_MAX_ATTEMPTS
);
   localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
   localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);

   logic [CODE_W-1:0]  lfsr_code;
   logic               lfsr_latch;
   logic [DIGIT_W-1:0] user_digit;
   logic               user_latch;
   logic               user_bksp;
   logic               unlock;
   logic               reset_sys;
   logic               expired;
   logic [ATT_W-1:0]   wrng_atmpt;
   logic [CODE_W-1:0]  otp;
   logic [CODE_W-1:0]  user_otp_out;

   modport master (
      output lfsr_code, lfsr_latch, user_digit, user_latch, user_bksp,
      input  unlock, reset_sys, expired, wrng_atmpt, otp, user_otp_out
   );

   modport slave (
      input  lfsr_code, lfsr_latch, user_digit, user_latch, user_bksp,
      output unlock, reset_sys, expired, wrng_atmpt, otp, user_otp_out
   );

endinterface

// File: rtl/otp_digit_buffer.sv
// Entered-digit storage with write index, backspace and clear; digit 0 is
// presented in the MSBs of the flattened output, unentered digits read 0.
module otp_digit_buffer #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIGIT_W    = 4,
   parameter int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clr,
   input  logic                          wr,
   input  logic                          bksp,
   input  logic [DIGIT_W-1:0]            din,
   output logic [IDX_W-1:0]              idx,
   output logic [NUM_DIGITS*DIGIT_W-1:0] dout
);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIGIT_W-1:0] digits [NUM_DIGITS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
         idx <= '0;
      end else if (clr) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
         idx <= '0;
      end else if (bksp) begin
         if (idx != '0) begin
            idx                    <= idx - 1'b1;
            digits[idx - 1'b1]     <= '0;
         end
      end else if (wr) begin
         digits[idx] <= din;
         // Index parks at 0 once full; the buffer is always cleared before reuse.
         idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   always_comb begin
      dout = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
         dout[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digits[i];
   end

endmodule

// File: rtl/otp_auth_ctrl.sv
// OTP authentication controller: captures a generated code, collects digits within
// a timed window, grants / locks out / expires. Define OTP_BACKSPACE_EN for backspace.
module otp_auth_ctrl
   import otp_auth_pkg::*;
#(
   parameter int unsigned     NUM_DIGITS    = DEF_NUM_DIGITS,
   parameter int unsigned     DIGIT_W       = DEF_DIGIT_W,
   parameter longint unsigned EXPIRE_CYCLES = DEF_EXPIRE_CYCLES,
   parameter longint unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int unsigned     MAX_ATTEMPTS  = DEF_MAX_ATTEMPTS
) (
   input logic            clk,
   input logic            reset,
   otp_auth_ctrl_if.slave bus
);
   localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);
   localparam int unsigned TMR_W  = tmr_width(EXPIRE_CYCLES, HOLD_CYCLES);

   localparam logic [TMR_W-1:0] EXP_LAST  = TMR_W'(EXPIRE_CYCLES - 64'd1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 64'd1);
   localparam logic [ATT_W-1:0] ATT_LAST  = ATT_W'(MAX_ATTEMPTS - 1);
   localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   state_t             state;
   logic [TMR_W-1:0]   timer;
   logic [CODE_W-1:0]  otp_q;
   logic [CODE_W-1:0]  buf_out;
   logic [ATT_W-1:0]   wrng_q;
   logic [IDX_W-1:0]   idx;
   logic               unlock_q, reset_sys_q, expired_q;
   logic               expire_now, in_hold, hold_done, code_match;
   logic               buf_wr, buf_bksp, buf_clr, digit_last;

   assign expire_now = (state == ENTER) && (timer == EXP_LAST);
   assign in_hold    = (state == GRANT) || (state == LOCKOUT) || (state == EXPIRED);
   assign hold_done  = in_hold && (timer == HOLD_LAST);
   assign code_match = (otp_q == buf_out);

`ifdef OTP_BACKSPACE_EN
   // A backspace at index 0 is treated as absent, so a coincident digit still lands.
   assign buf_bksp = (state == ENTER) && !expire_now && bus.user_bksp && (idx != '0);
`else
   logic bksp_unused;
   assign bksp_unused = bus.user_bksp;
   assign buf_bksp    = 1'b0;
`endif

   assign buf_wr     = (state == ENTER) && !expire_now && bus.user_latch && !buf_bksp;
   assign digit_last = buf_wr && (idx == IDX_LAST);
   assign buf_clr    = (state == IDLE) || hold_done ||
                       ((state == CHECK) && !code_match && (wrng_q != ATT_LAST));

   otp_digit_buffer #(
      .NUM_DIGITS (NUM_DIGITS),
      .DIGIT_W    (DIGIT_W),
      .IDX_W      (IDX_W)
   ) u_buf (
      .clk  (clk),
      .reset(reset),
      .clr  (buf_clr),
      .wr   (buf_wr),
      .bksp (buf_bksp),
      .din  (bus.user_digit),
      .idx  (idx),
      .dout (buf_out)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         timer       <= '0;
         otp_q       <= '0;
         wrng_q      <= '0;
         unlock_q    <= 1'b0;
         reset_sys_q <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               otp_q  <= '0;
               timer  <= '0;
               wrng_q <= '0;
               state  <= GEN;
            end
            GEN: begin
               if (bus.lfsr_latch) begin
                  otp_q <= bus.lfsr_code;
                  timer <= '0;
                  state <= ENTER;
               end
            end
            ENTER: begin
               if (expire_now) begin
                  timer     <= '0;
                  expired_q <= 1'b1;
                  state     <= EXPIRED;
               end else begin
                  timer <= timer + 1'b1;
                  if (digit_last) state <= CHECK;
               end
            end
            CHECK: begin
               if (code_match) begin
                  timer    <= '0;
                  unlock_q <= 1'b1;
                  state    <= GRANT;
               end else if (wrng_q == ATT_LAST) begin
                  timer       <= '0;
                  wrng_q      <= ATT_MAX;
                  reset_sys_q <= 1'b1;
                  state       <= LOCKOUT;
               end else begin
                  wrng_q <= wrng_q + 1'b1;
                  state  <= ENTER;
               end
            end
            GRANT, LOCKOUT, EXPIRED: begin
               // Clearing on exit as well makes the IDLE cycle itself read all-zero.
               if (hold_done) begin
                  timer       <= '0;
                  otp_q       <= '0;
                  wrng_q      <= '0;
                  unlock_q    <= 1'b0;
                  reset_sys_q <= 1'b0;
                  expired_q   <= 1'b0;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.unlock       = unlock_q;
   assign bus.reset_sys    = reset_sys_q;
   assign bus.expired      = expired_q;
   assign bus.wrng_atmpt   = wrng_q;
   assign bus.otp          = otp_q;
   assign bus.user_otp_out = buf_out;

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Scoreboard bench for otp_auth_ctrl: a reference model predicts outcome events,
// a negedge monitor pops and compares them as the DUT raises its indications.
`timescale 1ns/1ps
module tb_otp_auth_ctrl;
   localparam int unsigned ND   = 4;
   localparam int unsigned DW   = 4;
   localparam int unsigned EXP  = 100;
   localparam int unsigned HOLD = 10;
   localparam int unsigned MAXA = 3;
   localparam int unsigned CW   = ND * DW;

   typedef enum logic [1:0] {EV_WRONG, EV_UNLOCK, EV_LOCKOUT, EV_EXPIRED} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [31:0] at;
      logic [63:0] val;
   } ev_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   int unsigned cyc   = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   ev_t exp_q[$];

   // Reference model: the code, the digits currently entered, attempts, window use.
   logic [CW-1:0] m_code;
   int            m_digits[$];
   int unsigned   m_wrong;
   int unsigned   m_elapsed;
   int unsigned   m_hold_at;
   bit            m_done;

   otp_auth_ctrl_if #(.NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_ATTEMPTS(MAXA)) bus_if ();

   otp_auth_ctrl #(
      .NUM_DIGITS   (ND),
      .DIGIT_W      (DW),
      .EXPIRE_CYCLES(64'(EXP)),
      .HOLD_CYCLES  (64'(HOLD)),
      .MAX_ATTEMPTS (MAXA)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [CW-1:0] pack_digits();
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < m_digits.size(); i++) r[(ND-1-i)*DW +: DW] = DW'(m_digits[i]);
      return r;
   endfunction

   function automatic int code_digit(int k);
      return int'(m_code[(ND-1-k)*DW +: DW]);
   endfunction

   task automatic sb_event(ev_kind_t k, logic [63:0] v);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got %s at cycle %0d, expected none", k.name(), cyc);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      check("event_cycle", 64'(cyc), 64'(e.at));
      check("event_value", v, e.val);
   endtask

   // Monitor: indications rising and attempt counter stepping up are the DUT's outputs.
   logic [2:0]  hp = '0;
   logic [1:0]  p_wrng = '0;
   int unsigned hlen [3] = '{0, 0, 0};

   always @(negedge clk) begin
      logic [2:0] hc;
      if (!reset) begin
         hp     = '0;
         p_wrng = '0;
         for (int i = 0; i < 3; i++) hlen[i] = 0;
      end else begin
         hc = {bus_if.expired, bus_if.reset_sys, bus_if.unlock};
         if (bus_if.wrng_atmpt != p_wrng && bus_if.wrng_atmpt != '0)
            sb_event(EV_WRONG, 64'(bus_if.wrng_atmpt));
         if (hc[0] && !hp[0]) sb_event(EV_UNLOCK, 64'(bus_if.otp));
         if (hc[1] && !hp[1]) sb_event(EV_LOCKOUT, 64'(bus_if.wrng_atmpt));
         if (hc[2] && !hp[2]) sb_event(EV_EXPIRED, 64'(bus_if.user_otp_out));
         for (int i = 0; i < 3; i++) begin
            if (hc[i]) hlen[i]++;
            else if (hp[i]) begin
               check("hold_length", 64'(hlen[i]), 64'(HOLD));
               hlen[i] = 0;
            end
         end
         hp     = hc;
         p_wrng = bus_if.wrng_atmpt;
      end
   end

   task automatic drive_quiet();
      bus_if.lfsr_latch = 1'b0;
      bus_if.user_latch = 1'b0;
      bus_if.user_bksp  = 1'b0;
      bus_if.user_digit = '0;
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_unlock"}, 64'(bus_if.unlock), 64'd0);
      check({tag, "_reset_sys"}, 64'(bus_if.reset_sys), 64'd0);
      check({tag, "_expired"}, 64'(bus_if.expired), 64'd0);
      check({tag, "_wrng"}, 64'(bus_if.wrng_atmpt), 64'd0);
      check({tag, "_otp"}, 64'(bus_if.otp), 64'd0);
      check({tag, "_user_otp"}, 64'(bus_if.user_otp_out), 64'd0);
   endtask

   // Called at a negedge with the DUT waiting for a code.
   task automatic start_session(logic [CW-1:0] code);
      bus_if.lfsr_code  = code;
      bus_if.lfsr_latch = 1'b1;
      @(negedge clk);
      bus_if.lfsr_latch = 1'b0;
      bus_if.lfsr_code  = CW'($urandom);
      m_code    = code;
      m_digits.delete();
      m_wrong   = 0;
      m_elapsed = 0;
      m_done    = 1'b0;
      check("otp_captured", 64'(bus_if.otp), 64'(code));
   endtask

   // One cycle of the entry window; predicts any outcome the inputs provoke.
   task automatic enter_cycle(bit latch, int digit, bit bksp, bit stray_lfsr);
      int unsigned c;
      c = cyc;
      bus_if.user_latch = latch;
      bus_if.user_digit = DW'(digit);
      bus_if.user_bksp  = bksp;
      bus_if.lfsr_latch = stray_lfsr;
      bus_if.lfsr_code  = CW'($urandom);
      if (m_elapsed == EXP - 1) begin
         m_done    = 1'b1;
         m_hold_at = c + 1;
         exp_q.push_back('{EV_EXPIRED, 32'(c + 1), 64'(pack_digits())});
      end else begin
         m_elapsed++;
`ifdef OTP_BACKSPACE_EN
         if (bksp && m_digits.size() > 0) void'(m_digits.pop_back());
         else if (latch) m_digits.push_back(digit);
`else
         if (latch) m_digits.push_back(digit);
`endif
      end
      @(negedge clk);
      drive_quiet();
      check("otp_held", 64'(bus_if.otp), 64'(m_code));
      if (!m_done) check("user_otp_out", 64'(bus_if.user_otp_out), 64'(pack_digits()));
      if (!m_done && m_digits.size() == ND) begin
         if (pack_digits() == m_code) begin
            exp_q.push_back('{EV_UNLOCK, 32'(c + 2), 64'(m_code)});
            m_done    = 1'b1;
            m_hold_at = c + 2;
         end else begin
            m_wrong++;
            exp_q.push_back('{EV_WRONG, 32'(c + 2), 64'(m_wrong)});
            if (m_wrong == MAXA) begin
               exp_q.push_back('{EV_LOCKOUT, 32'(c + 2), 64'(MAXA)});
               m_done    = 1'b1;
               m_hold_at = c + 2;
            end
         end
         m_digits.delete();
         // Comparison cycle: keypad and code inputs must be ignored here.
         bus_if.user_latch = 1'($urandom_range(0, 1));
         bus_if.user_bksp  = 1'($urandom_range(0, 1));
         bus_if.lfsr_latch = 1'($urandom_range(0, 1));
         @(negedge clk);
         drive_quiet();
      end
   endtask

   task automatic complete_session();
      while (!m_done) enter_cycle(1'b1, code_digit(m_digits.size()), 1'b0, 1'b0);
   endtask

   // Rides out the hold with ignored noise, checks the IDLE cycle, ends in GEN.
   task automatic finish_session();
      while (cyc < m_hold_at + HOLD) begin
         bus_if.lfsr_latch = 1'($urandom_range(0, 1));
         bus_if.lfsr_code  = CW'($urandom);
         bus_if.user_latch = 1'($urandom_range(0, 1));
         bus_if.user_bksp  = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      drive_quiet();
      check_all_zero("idle");
      bus_if.lfsr_latch = 1'b1;
      bus_if.lfsr_code  = CW'($urandom);
      @(negedge clk);
      drive_quiet();
      check("gen_otp_still_zero", 64'(bus_if.otp), 64'd0);
   endtask

   task automatic apply_reset();
      #2 reset = 1'b0;
      #1 check_all_zero("async_reset");
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic random_session();
      bit slow;
      int unsigned r, latch_p;
      int d;
      bit bk, stray;
      slow    = ($urandom_range(0, 3) == 0);
      latch_p = slow ? 4 : 60;
      start_session(CW'($urandom));
      while (!m_done) begin
         r     = $urandom_range(0, 99);
         stray = ($urandom_range(0, 9) == 0);
         if (r < latch_p) begin
            d  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : code_digit(m_digits.size());
            bk = (m_digits.size() > 0) && ($urandom_range(0, 9) == 0);
            enter_cycle(1'b1, d, bk, stray);
         end else if (r < latch_p + 8) begin
            enter_cycle(1'b0, 0, 1'b1, stray);
         end else begin
            enter_cycle(1'b0, 0, 1'b0, stray);
         end
      end
      finish_session();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.lfsr_code = '0;
      drive_quiet();
      @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b1;
      @(negedge clk);

      // Correct entry of 0x1234.
      start_session(16'h1234);
      enter_cycle(1'b1, 1, 1'b0, 1'b0);
      enter_cycle(1'b1, 2, 1'b0, 1'b0);
      enter_cycle(1'b0, 0, 1'b0, 1'b0);
      enter_cycle(1'b1, 3, 1'b0, 1'b0);
      enter_cycle(1'b1, 4, 1'b0, 1'b0);
      check("grant_done", 64'(m_done), 64'd1);
      finish_session();

      // Three all-zero attempts lead to lockout.
      start_session(16'h1234);
      for (int a = 0; a < 3; a++)
         for (int k = 0; k < 4; k++) enter_cycle(1'b1, 0, 1'b0, 1'b0);
      finish_session();

      // Expiry after two digits, with a digit strobed on the expiry cycle.
      start_session(16'h5A3C);
      enter_cycle(1'b1, 5, 1'b0, 1'b0);
      enter_cycle(1'b1, 10, 1'b0, 1'b0);
      while (!m_done) enter_cycle(m_elapsed == EXP - 1, 7, 1'b0, 1'b0);
      finish_session();

      // Backspace sequence, including a backspace with nothing entered.
      start_session(16'h1234);
      enter_cycle(1'b0, 0, 1'b1, 1'b0);
      enter_cycle(1'b1, 1, 1'b0, 1'b0);
      enter_cycle(1'b1, 9, 1'b0, 1'b0);
      enter_cycle(1'b0, 0, 1'b1, 1'b0);
      enter_cycle(1'b1, 2, 1'b0, 1'b0);
      enter_cycle(1'b1, 3, 1'b0, 1'b0);
      enter_cycle(1'b1, 4, 1'b0, 1'b0);
`ifdef OTP_BACKSPACE_EN
      check("bksp_unlock", 64'(bus_if.unlock), 64'd1);
`else
      check("nobksp_wrng", 64'(bus_if.wrng_atmpt), 64'd1);
      check("nobksp_buffer", 64'(bus_if.user_otp_out), 64'h4000);
`endif
      complete_session();
      finish_session();

      // Stray code strobes during entry, then reset in the middle of the grant hold.
      start_session(16'hBEEF);
      enter_cycle(1'b1, 11, 1'b0, 1'b1);
      enter_cycle(1'b0, 0, 1'b0, 1'b1);
      enter_cycle(1'b1, 14, 1'b0, 1'b1);
      enter_cycle(1'b1, 14, 1'b0, 1'b1);
      enter_cycle(1'b1, 15, 1'b0, 1'b1);
      while (cyc < m_hold_at + 5) @(negedge clk);
      check("unlock_before_reset", 64'(bus_if.unlock), 64'd1);
      apply_reset();

      for (int s = 0; s < 30; s++) random_session();

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
